// File: rtl/minirv_mem_pkg.sv
// Shared encodings and request checks for the miniRV data-memory path.
package minirv_mem_pkg;

    typedef enum logic [1:0] {
        OP_LW  = 2'b00,
        OP_LBU = 2'b01,
        OP_SW  = 2'b10,
        OP_SB  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACCESS = 2'b01,
        S_RESP   = 2'b10
    } state_e;

    localparam int unsigned ADDR_BITS_DEFAULT = 26;

    // Word ops need 4-byte alignment; byte ops never fault on alignment.
    function automatic logic req_error(input op_e op, input logic [31:0] addr,
                                       input int unsigned addr_bits);
        logic w_oor;
        logic w_mis;
        w_oor = (addr_bits < 32) ? ((addr >> addr_bits) != 32'd0) : 1'b0;
        w_mis = ((op == OP_LW) || (op == OP_SW)) && (addr[1:0] != 2'b00);
        return w_oor | w_mis;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: request handshake plus response.
interface dmem_arbiter_if;

    logic                 valid;
    logic                 ready;
    minirv_mem_pkg::op_e  op;
    logic [31:0]          addr;
    logic [31:0]          wdata;
    logic                 rsp_valid;
    logic [31:0]          rsp_rdata;
    logic                 rsp_err;

    modport master (
        output valid, op, addr, wdata,
        input  ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  valid, op, addr, wdata,
        output ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; a tie goes to the port not granted last.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic r_last;

    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = r_last ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end

    // r_last starts at 1 so port 0 takes the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (update && (grant != 2'b00)) begin
            r_last <= grant[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer for the miniRV byte-lane data memory:
// round-robin grant, alignment/range check, one-cycle strobes, registered response.
module dmem_arbiter
    import minirv_mem_pkg::*;
#(
    parameter int unsigned ADDR_BITS = ADDR_BITS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_arbiter_if.slave     m0,
    dmem_arbiter_if.slave     m1,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_sw,
    output logic              mem_sb,
    output logic              mem_lw,
    output logic              mem_lbu,
    input  logic [31:0]       mem_rdata
);

    state_e      r_state;
    op_e         r_op;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_id;
    logic [1:0]  r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic        r_sw;
    logic        r_sb;
    logic        r_lw;
    logic        r_lbu;

    logic [1:0]  w_req;
    logic [1:0]  w_grant;
    logic        w_accept;
    logic        w_sel;
    op_e         w_op;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_err;
    logic        w_is_load;

    // Requests are only visible to the arbiter in IDLE, so ready drops elsewhere.
    assign w_req = (r_state == S_IDLE) ? {m1.valid, m0.valid} : 2'b00;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (w_req),
        .update (w_accept),
        .grant  (w_grant)
    );

    assign w_accept  = |w_grant;
    assign w_sel     = w_grant[1];
    assign w_op      = w_sel ? m1.op    : m0.op;
    assign w_addr    = w_sel ? m1.addr  : m0.addr;
    assign w_wdata   = w_sel ? m1.wdata : m0.wdata;
    assign w_err     = req_error(w_op, w_addr, ADDR_BITS);
    assign w_is_load = (r_op == OP_LW) || (r_op == OP_LBU);

    assign m0.ready = w_grant[0];
    assign m1.ready = w_grant[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= OP_LW;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_id        <= 1'b0;
            r_rsp_valid <= 2'b00;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_sw        <= 1'b0;
            r_sb        <= 1'b0;
            r_lw        <= 1'b0;
            r_lbu       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= w_op;
                        r_addr  <= w_addr;
                        r_wdata <= w_wdata;
                        r_id    <= w_sel;
                        if (w_err) begin
                            // Faulting request skips memory and answers next cycle.
                            r_state     <= S_RESP;
                            r_rsp_valid <= w_grant;
                            r_rsp_rdata <= 32'd0;
                            r_rsp_err   <= 1'b1;
                        end else begin
                            r_state <= S_ACCESS;
                            r_sw    <= (w_op == OP_SW);
                            r_sb    <= (w_op == OP_SB);
                            r_lw    <= (w_op == OP_LW);
                            r_lbu   <= (w_op == OP_LBU);
                        end
                    end
                end
                S_ACCESS: begin
                    r_state     <= S_RESP;
                    r_sw        <= 1'b0;
                    r_sb        <= 1'b0;
                    r_lw        <= 1'b0;
                    r_lbu       <= 1'b0;
                    r_rsp_valid <= r_id ? 2'b10 : 2'b01;
                    r_rsp_rdata <= w_is_load ? mem_rdata : 32'd0;
                    r_rsp_err   <= 1'b0;
                end
                S_RESP: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 2'b00;
                    r_rsp_rdata <= 32'd0;
                    r_rsp_err   <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_sw    = r_sw;
    assign mem_sb    = r_sb;
    assign mem_lw    = r_lw;
    assign mem_lbu   = r_lbu;

    // Only the owning port sees response data; the other port reads all zeros.
    assign m0.rsp_valid = r_rsp_valid[0];
    assign m0.rsp_rdata = r_rsp_valid[0] ? r_rsp_rdata : 32'd0;
    assign m0.rsp_err   = r_rsp_valid[0] & r_rsp_err;
    assign m1.rsp_valid = r_rsp_valid[1];
    assign m1.rsp_rdata = r_rsp_valid[1] ? r_rsp_rdata : 32'd0;
    assign m1.rsp_err   = r_rsp_valid[1] & r_rsp_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array memory, event monitor and a transaction-level reference model.
module tb_dmem_arbiter;
    import minirv_mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if m0_if ();
    dmem_arbiter_if m1_if ();

    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_sw, mem_sb, mem_lw, mem_lbu;

    dmem_arbiter #(.ADDR_BITS(26)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0        (m0_if),
        .m1        (m1_if),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_sw    (mem_sw),
        .mem_sb    (mem_sb),
        .mem_lw    (mem_lw),
        .mem_lbu   (mem_lbu),
        .mem_rdata (mem_rdata)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Physical memory the DUT talks to (1 KiB window, wraps on addr[9:0]).
    logic [7:0] phys_mem [1024] = '{default: 8'h00};
    logic [9:0] pa;
    assign pa = mem_addr[9:0];

    always_comb begin
        mem_rdata = 32'd0;
        if (mem_lw)
            mem_rdata = {phys_mem[pa + 10'd3], phys_mem[pa + 10'd2], phys_mem[pa + 10'd1], phys_mem[pa]};
        else if (mem_lbu)
            mem_rdata = {24'd0, phys_mem[pa]};
    end

    always @(posedge clk) begin
        if (mem_sw) begin
            phys_mem[pa]         <= mem_wdata[7:0];
            phys_mem[pa + 10'd1] <= mem_wdata[15:8];
            phys_mem[pa + 10'd2] <= mem_wdata[23:16];
            phys_mem[pa + 10'd3] <= mem_wdata[31:24];
        end else if (mem_sb) begin
            phys_mem[pa] <= mem_wdata[7:0];
        end
    end

    // Reference memory image, advanced one transaction at a time in accept order.
    logic [7:0] ref_mem [1024] = '{default: 8'h00};

    function automatic void model_txn(input logic [1:0] op, input logic [31:0] addr,
                                      input logic [31:0] wdata, output logic err,
                                      output logic [31:0] rdata);
        int unsigned a;
        a = addr % 1024;
        err = (addr >= 32'h0400_0000) || (((op == OP_LW) || (op == OP_SW)) && ((addr % 4) != 0));
        rdata = 32'd0;
        if (!err) begin
            case (op)
                OP_LW:  for (int k = 0; k < 4; k++) rdata[8*k +: 8] = ref_mem[(a + k) % 1024];
                OP_LBU: rdata = {24'd0, ref_mem[a]};
                OP_SW:  for (int k = 0; k < 4; k++) ref_mem[(a + k) % 1024] = wdata[8*k +: 8];
                default: ref_mem[a] = wdata[7:0];
            endcase
        end
    endfunction

    function automatic logic [3:0] exp_strobe(input logic [1:0] op);
        case (op)
            OP_SW:   return 4'b1000;
            OP_SB:   return 4'b0100;
            OP_LW:   return 4'b0010;
            default: return 4'b0001;
        endcase
    endfunction

    // Passive monitor sampling mid-cycle.
    typedef struct { int cyc; int port; logic [1:0] op; logic [31:0] addr; logic [31:0] wdata; } acc_t;
    typedef struct { int cyc; logic [3:0] s; logic [31:0] addr; logic [31:0] wdata; } strb_t;
    typedef struct { int cyc; int port; logic [31:0] rdata; logic err; } rsp_t;
    acc_t  acc_q[$];
    strb_t strb_q[$];
    rsp_t  rsp_q[$];
    int dual_ready = 0;
    int junk = 0;

    always @(negedge clk) begin
        if (m0_if.valid && m0_if.ready) acc_q.push_back('{cyc, 0, m0_if.op, m0_if.addr, m0_if.wdata});
        if (m1_if.valid && m1_if.ready) acc_q.push_back('{cyc, 1, m1_if.op, m1_if.addr, m1_if.wdata});
        if (m0_if.ready && m1_if.ready) dual_ready++;
        if ({mem_sw, mem_sb, mem_lw, mem_lbu} != 4'b0000)
            strb_q.push_back('{cyc, {mem_sw, mem_sb, mem_lw, mem_lbu}, mem_addr, mem_wdata});
        if (m0_if.rsp_valid) rsp_q.push_back('{cyc, 0, m0_if.rsp_rdata, m0_if.rsp_err});
        if (m1_if.rsp_valid) rsp_q.push_back('{cyc, 1, m1_if.rsp_rdata, m1_if.rsp_err});
        if (!m0_if.rsp_valid && (m0_if.rsp_rdata != 32'd0 || m0_if.rsp_err)) junk++;
        if (!m1_if.rsp_valid && (m1_if.rsp_rdata != 32'd0 || m1_if.rsp_err)) junk++;
    end

    task automatic clear_logs();
        acc_q.delete();
        strb_q.delete();
        rsp_q.delete();
        dual_ready = 0;
        junk = 0;
    endtask

    task automatic set_req(input int port, input logic v, input logic [1:0] op,
                           input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            m0_if.valid = v; m0_if.op = op_e'(op); m0_if.addr = addr; m0_if.wdata = wdata;
        end else begin
            m1_if.valid = v; m1_if.op = op_e'(op); m1_if.addr = addr; m1_if.wdata = wdata;
        end
    endtask

    function automatic void rand_req(output logic [1:0] op, output logic [31:0] addr,
                                     output logic [31:0] wdata);
        op = 2'($urandom_range(0, 3));
        addr = 32'($urandom_range(0, 15)) * 32'd4;
        if ($urandom_range(0, 3) == 0) addr = addr + 32'($urandom_range(1, 3));
        if ($urandom_range(0, 7) == 0) addr = addr | (32'h0400_0000 << $urandom_range(0, 5));
        wdata = $urandom;
    endfunction

    // Present one request, wait (bounded) for its accept, then let it drain.
    task automatic send_one(input int port, input logic [1:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, output bit ok);
        ok = 1'b0;
        set_req(port, 1'b1, op, addr, wdata);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if ((port == 0) ? m0_if.ready : m1_if.ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        set_req(port, 1'b0, op, addr, wdata);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({m0_if.rsp_valid, m0_if.rsp_err, m1_if.rsp_valid, m1_if.rsp_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_rsp_flags: got %b required 0000",
                     {m0_if.rsp_valid, m0_if.rsp_err, m1_if.rsp_valid, m1_if.rsp_err});
        end
        checks++;
        if ({m0_if.rsp_rdata, m1_if.rsp_rdata} !== 64'd0) begin
            errors++;
            $display("FAIL reset_rsp_rdata: got %h/%h required 0", m0_if.rsp_rdata, m1_if.rsp_rdata);
        end
        checks++;
        if ({mem_sw, mem_sb, mem_lw, mem_lbu} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes: got %b required 0000", {mem_sw, mem_sb, mem_lw, mem_lbu});
        end
        checks++;
        if ({mem_addr, mem_wdata} !== 64'd0) begin
            errors++;
            $display("FAIL reset_mem_bus: got addr %h wdata %h required 0", mem_addr, mem_wdata);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        bit ok0, ok1;
        logic e0, e1;
        logic [31:0] d0, d1;
        clear_logs();
        model_txn(OP_SW, 32'h10, 32'hA1B2C3D4, e0, d0);
        model_txn(OP_LW, 32'h10, 32'd0, e1, d1);
        send_one(0, OP_SW, 32'h10, 32'hA1B2C3D4, ok0);
        send_one(0, OP_LW, 32'h10, $urandom, ok1);
        checks++;
        if (!(ok0 && ok1) || acc_q.size() != 2) begin
            errors++;
            $display("FAIL sl_accept: got %0d accepts (timeout=%0b) required 2", acc_q.size(), !(ok0 && ok1));
        end else begin
            checks++;
            if (strb_q.size() != 2 || strb_q[0].s != 4'b1000 || strb_q[0].cyc != acc_q[0].cyc + 1
                || strb_q[0].addr != 32'h10 || strb_q[0].wdata != 32'hA1B2C3D4) begin
                errors++;
                $display("FAIL sl_sw_strobe: got %0d strobe cycles, first %b at +%0d required one 1000 at +1",
                         strb_q.size(), strb_q.size() > 0 ? strb_q[0].s : 4'b0,
                         strb_q.size() > 0 ? strb_q[0].cyc - acc_q[0].cyc : -1);
            end
            checks++;
            if (rsp_q.size() != 2 || rsp_q[1].port != 0 || rsp_q[1].cyc != acc_q[1].cyc + 2
                || rsp_q[1].rdata !== d1 || rsp_q[1].err !== e1 || rsp_q[0].rdata !== d0) begin
                errors++;
                $display("FAIL sl_lw_rsp: got %0d rsps, rdata %h err %b at +%0d required %h err %b at +2",
                         rsp_q.size(), rsp_q.size() > 1 ? rsp_q[1].rdata : 32'hx,
                         rsp_q.size() > 1 ? rsp_q[1].err : 1'bx,
                         rsp_q.size() > 1 ? rsp_q[1].cyc - acc_q[1].cyc : -1, d1, e1);
            end
        end
    endtask

    task automatic test_byte();
        bit ok0, ok1, ok2;
        logic e0, e1, e2;
        logic [31:0] d0, d1, d2, wd;
        clear_logs();
        wd = {$urandom_range(1, 255), 8'h55};
        model_txn(OP_SB, 32'h13, wd, e0, d0);
        model_txn(OP_LBU, 32'h13, 32'd0, e1, d1);
        model_txn(OP_LBU, 32'h12, 32'd0, e2, d2);
        send_one(1, OP_SB, 32'h13, wd, ok0);
        send_one(1, OP_LBU, 32'h13, 32'd0, ok1);
        send_one(1, OP_LBU, 32'h12, 32'd0, ok2);
        checks++;
        if (!(ok0 && ok1 && ok2) || rsp_q.size() != 3 || strb_q.size() != 3) begin
            errors++;
            $display("FAIL byte_count: got %0d rsps %0d strobes required 3/3", rsp_q.size(), strb_q.size());
        end else begin
            checks++;
            if (rsp_q[0].port != 1 || rsp_q[1].port != 1 || rsp_q[2].port != 1) begin
                errors++;
                $display("FAIL byte_port: got ports %0d %0d %0d required 1 1 1",
                         rsp_q[0].port, rsp_q[1].port, rsp_q[2].port);
            end
            checks++;
            if (strb_q[0].s != 4'b0100 || strb_q[1].s != 4'b0001) begin
                errors++;
                $display("FAIL byte_strobe: got %b %b required 0100 0001", strb_q[0].s, strb_q[1].s);
            end
            checks++;
            if (rsp_q[1].rdata !== d1) begin
                errors++;
                $display("FAIL byte_lbu13: got %h required %h", rsp_q[1].rdata, d1);
            end
            checks++;
            if (rsp_q[2].rdata !== d2) begin
                errors++;
                $display("FAIL byte_lbu12: got %h required %h", rsp_q[2].rdata, d2);
            end
        end
    endtask

    task automatic test_misaligned();
        bit ok0, ok1;
        logic e0, e1;
        logic [31:0] d0, d1, wd;
        clear_logs();
        wd = $urandom;
        model_txn(OP_LW, 32'h11, 32'd0, e0, d0);
        model_txn(OP_SW, 32'h20, wd, e1, d1);
        ok0 = 1'b0;
        ok1 = 1'b0;
        set_req(0, 1'b1, OP_LW, 32'h11, 32'd0);
        for (int k = 0; k < 20 && !ok0; k++) begin
            @(negedge clk);
            ok0 = m0_if.ready;
        end
        @(posedge clk); #1;
        set_req(0, 1'b1, OP_SW, 32'h20, wd);
        for (int k = 0; k < 20 && !ok1; k++) begin
            @(negedge clk);
            ok1 = m0_if.ready;
        end
        @(posedge clk); #1;
        set_req(0, 1'b0, OP_SW, 32'h20, wd);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (!(ok0 && ok1) || acc_q.size() != 2 || rsp_q.size() != 2) begin
            errors++;
            $display("FAIL mis_count: got %0d accepts %0d rsps required 2/2", acc_q.size(), rsp_q.size());
        end else begin
            checks++;
            if (rsp_q[0].err !== e0 || rsp_q[0].rdata !== d0 || rsp_q[0].cyc != acc_q[0].cyc + 1) begin
                errors++;
                $display("FAIL mis_rsp: got err %b rdata %h at +%0d required err %b rdata %h at +1",
                         rsp_q[0].err, rsp_q[0].rdata, rsp_q[0].cyc - acc_q[0].cyc, e0, d0);
            end
            checks++;
            if (acc_q[1].cyc - acc_q[0].cyc != 2) begin
                errors++;
                $display("FAIL mis_next_accept: got +%0d required +2", acc_q[1].cyc - acc_q[0].cyc);
            end
            checks++;
            if (strb_q.size() != 1 || strb_q[0].cyc != acc_q[1].cyc + 1) begin
                errors++;
                $display("FAIL mis_no_strobe: got %0d strobe cycles required 1 (store only)", strb_q.size());
            end
        end
    endtask

    task automatic test_out_of_range();
        bit ok0, ok1;
        logic e0, e1;
        logic [31:0] d0, d1, wd;
        clear_logs();
        wd = $urandom | 32'h0101_0101;
        model_txn(OP_SW, 32'h0400_0000, wd, e0, d0);
        model_txn(OP_LW, 32'h0, 32'd0, e1, d1);
        send_one(1, OP_SW, 32'h0400_0000, wd, ok0);
        send_one(1, OP_LW, 32'h0, 32'd0, ok1);
        checks++;
        if (!(ok0 && ok1) || rsp_q.size() != 2) begin
            errors++;
            $display("FAIL oor_count: got %0d rsps required 2", rsp_q.size());
        end else begin
            checks++;
            if (rsp_q[0].err !== e0 || rsp_q[0].port != 1) begin
                errors++;
                $display("FAIL oor_err: got err %b port %0d required err %b port 1",
                         rsp_q[0].err, rsp_q[0].port, e0);
            end
            checks++;
            if (rsp_q[1].rdata !== d1 || rsp_q[1].err !== e1) begin
                errors++;
                $display("FAIL oor_readback: got %h required %h", rsp_q[1].rdata, d1);
            end
        end
        checks++;
        if (strb_q.size() != 1 || strb_q[0].s != 4'b0010) begin
            errors++;
            $display("FAIL oor_strobes: got %0d strobe cycles required 1 (lw)", strb_q.size());
        end
    endtask

    task automatic test_alternation();
        logic [1:0]  op;
        logic [31:0] addr, wd, d;
        logic        e;
        bit          hit0, hit1;
        int          n_acc, s_idx, gap;
        clear_logs();
        rand_req(op, addr, wd); set_req(0, 1'b1, op, addr, wd);
        rand_req(op, addr, wd); set_req(1, 1'b1, op, addr, wd);
        n_acc = 0;
        for (int k = 0; k < 100 && n_acc < 10; k++) begin
            @(negedge clk);
            hit0 = m0_if.ready;
            hit1 = m1_if.ready;
            @(posedge clk); #1;
            if (hit0) begin n_acc++; rand_req(op, addr, wd); set_req(0, 1'b1, op, addr, wd); end
            if (hit1) begin n_acc++; rand_req(op, addr, wd); set_req(1, 1'b1, op, addr, wd); end
        end
        set_req(0, 1'b0, op, addr, wd);
        set_req(1, 1'b0, op, addr, wd);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (acc_q.size() != 10) begin
            errors++;
            $display("FAIL rr_accept_count: got %0d required 10", acc_q.size());
        end else begin
            s_idx = 0;
            for (int i = 0; i < acc_q.size(); i++) begin
                model_txn(acc_q[i].op, acc_q[i].addr, acc_q[i].wdata, e, d);
                checks++;
                if (acc_q[i].port != i % 2) begin
                    errors++;
                    $display("FAIL rr_grant[%0d]: got m%0d required m%0d", i, acc_q[i].port, i % 2);
                end
                if (i + 1 < acc_q.size()) begin
                    gap = acc_q[i+1].cyc - acc_q[i].cyc;
                    checks++;
                    if (gap != (e ? 2 : 3)) begin
                        errors++;
                        $display("FAIL rr_spacing[%0d]: got %0d cycles required %0d", i, gap, e ? 2 : 3);
                    end
                end
                checks++;
                if (i >= rsp_q.size() || rsp_q[i].port != acc_q[i].port
                    || rsp_q[i].cyc != acc_q[i].cyc + (e ? 1 : 2)
                    || rsp_q[i].rdata !== d || rsp_q[i].err !== e) begin
                    errors++;
                    $display("FAIL rr_rsp[%0d]: got port %0d rdata %h err %b at +%0d required port %0d rdata %h err %b at +%0d",
                             i, i < rsp_q.size() ? rsp_q[i].port : -1,
                             i < rsp_q.size() ? rsp_q[i].rdata : 32'hx,
                             i < rsp_q.size() ? rsp_q[i].err : 1'bx,
                             i < rsp_q.size() ? rsp_q[i].cyc - acc_q[i].cyc : -1,
                             acc_q[i].port, d, e, e ? 1 : 2);
                end
                if (!e) begin
                    checks++;
                    if (s_idx >= strb_q.size() || strb_q[s_idx].cyc != acc_q[i].cyc + 1
                        || strb_q[s_idx].s != exp_strobe(acc_q[i].op)
                        || strb_q[s_idx].addr != acc_q[i].addr) begin
                        errors++;
                        $display("FAIL rr_strobe[%0d]: got %b addr %h required %b addr %h at +1",
                                 i, s_idx < strb_q.size() ? strb_q[s_idx].s : 4'b0,
                                 s_idx < strb_q.size() ? strb_q[s_idx].addr : 32'hx,
                                 exp_strobe(acc_q[i].op), acc_q[i].addr);
                    end
                    s_idx++;
                end
            end
            checks++;
            if (strb_q.size() != s_idx || rsp_q.size() != acc_q.size()) begin
                errors++;
                $display("FAIL rr_extra_events: got %0d strobes %0d rsps required %0d/%0d",
                         strb_q.size(), rsp_q.size(), s_idx, acc_q.size());
            end
        end
        checks++;
        if (dual_ready != 0 || junk != 0) begin
            errors++;
            $display("FAIL rr_exclusive: got %0d dual-ready cycles %0d stray rsp cycles required 0/0",
                     dual_ready, junk);
        end
    endtask

    task automatic test_reset_mid();
        bit ok, ok1;
        int t0;
        logic e0, e1;
        logic [31:0] d0, d1;
        clear_logs();
        ok = 1'b0;
        set_req(0, 1'b1, OP_LW, 32'h10, 32'd0);
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = m0_if.ready;
        end
        @(posedge clk); #1;
        set_req(0, 1'b0, OP_LW, 32'h10, 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_logs();
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (!ok || rsp_q.size() != 0 || strb_q.size() != 0) begin
            errors++;
            $display("FAIL rstmid_abort: got %0d rsps %0d strobes after reset (accepted=%0b) required 0/0",
                     rsp_q.size(), strb_q.size(), ok);
        end
        clear_logs();
        model_txn(OP_LW, 32'h10, 32'd0, e0, d0);
        model_txn(OP_LW, 32'h14, 32'd0, e1, d1);
        t0 = cyc;
        set_req(0, 1'b1, OP_LW, 32'h10, 32'd0);
        set_req(1, 1'b1, OP_LW, 32'h14, 32'd0);
        ok1 = 1'b0;
        for (int k = 0; k < 30 && !ok1; k++) begin
            @(negedge clk);
            if (m0_if.ready) begin
                @(posedge clk); #1;
                set_req(0, 1'b0, OP_LW, 32'h10, 32'd0);
            end else if (m1_if.ready) begin
                ok1 = 1'b1;
                @(posedge clk); #1;
                set_req(1, 1'b0, OP_LW, 32'h14, 32'd0);
            end
        end
        set_req(0, 1'b0, OP_LW, 32'h10, 32'd0);
        set_req(1, 1'b0, OP_LW, 32'h14, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (acc_q.size() != 2 || acc_q[0].port != 0 || acc_q[0].cyc != t0) begin
            errors++;
            $display("FAIL rstmid_first_tie: got %0d accepts, first m%0d at +%0d required m0 at +0",
                     acc_q.size(), acc_q.size() > 0 ? acc_q[0].port : -1,
                     acc_q.size() > 0 ? acc_q[0].cyc - t0 : -1);
        end
        checks++;
        if (rsp_q.size() != 2 || rsp_q[0].rdata !== d0 || rsp_q[1].rdata !== d1 || rsp_q[1].port != 1) begin
            errors++;
            $display("FAIL rstmid_rsp: got %0d rsps rdata %h/%h required %h/%h",
                     rsp_q.size(), rsp_q.size() > 0 ? rsp_q[0].rdata : 32'hx,
                     rsp_q.size() > 1 ? rsp_q[1].rdata : 32'hx, d0, d1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        set_req(0, 1'b0, OP_LW, 32'd0, 32'd0);
        set_req(1, 1'b0, OP_LW, 32'd0, 32'd0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_store_load();
        test_byte();
        test_misaligned();
        test_out_of_range();
        test_alternation();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
